score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
Parameters:
REQ-001 WIN_SCORE, default 7: points needed to win; legal range 1..15.
REQ-002 SERVE_DELAY, default 50_000_000: cycles spent in SERVE before play resumes; legal minimum 1.

Ports:
REQ-003 clk  input  1  master 50 MHz clock; only clock of the block.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 start  input  1  start/restart button, synchronous to clk, level; acted on at rising edge only.
REQ-006 player1_point  input  1  scoring flag from ball tracker; player 1 scored.
REQ-007 player2_point  input  1  scoring flag from ball tracker; player 2 scored.
REQ-008 game_on  output  1  high only while state is PLAY; drives ball tracker enable.
REQ-009 ball_rst_n  output  1  active-low reset to ball tracker; low in every state except PLAY.
REQ-010 score1, score2  output  4  current scores, unsigned.
REQ-011 game_over  output  1  high only while state is OVER.
REQ-012 winner  output  2  00 none, 01 player 1, 10 player 2; 11 never driven.

Function
REQ-013 FSM states SHALL be IDLE, SERVE, PLAY, POINT, OVER; all outputs decode from registered state and registered scores (no input-to-output combinational path).
REQ-014 start, player1_point and player2_point SHALL each be edge-detected against a registered previous-cycle copy; only a 0-to-1 transition counts as an event.
REQ-015 IDLE: on start event, next state SERVE and serve counter cleared.
REQ-016 SERVE: stay exactly SERVE_DELAY cycles, then PLAY; counter width sufficient for SERVE_DELAY without wrap.
REQ-017 PLAY: on exactly one point event, increment that player's score at the same edge and enter POINT; with no event, stay in PLAY.
REQ-018 PLAY: both point events in the same cycle SHALL change neither score and enter POINT (replay).
REQ-019 POINT: one cycle; if a win condition holds, enter OVER and latch winner; otherwise enter SERVE with counter cleared.
REQ-020 Win condition (macro absent): score >= WIN_SCORE.
REQ-021 Scores SHALL saturate at 15; no wrap-around.
REQ-022 OVER: hold scores and winner; on start event, clear scores and winner to 0 and enter SERVE.
REQ-023 Point events SHALL be ignored in every state other than PLAY; start events ignored in SERVE, PLAY and POINT.
REQ-024 Latency: point input first sampled high at edge k updates score at edge k; game_on is low and ball_rst_n is low from edge k; OVER or SERVE is entered at edge k+1.

Reset
REQ-025 With reset low at a rising clk edge, the next state SHALL be IDLE, from any state including mid-SERVE count and POINT.
REQ-026 Reset values: score1=0, score2=0, winner=00, game_over=0, game_on=0, ball_rst_n=0, serve counter 0, edge-detect registers 0.
REQ-027 A start held high through reset release SHALL NOT count as an event; it must fall and rise again.

Configuration
REQ-028 Macro SCORE_KEEPER_WIN_BY_TWO_EN defined: win condition becomes score >= WIN_SCORE AND (lead >= 2 OR score == 15).
REQ-029 Macro absent: win condition per REQ-020, and no lead-comparison logic is synthesized.

Verification
REQ-030 WIN_SCORE=3, SERVE_DELAY=4; reset, start pulse -> SERVE for 4 cycles, then game_on=1 and ball_rst_n=1.
REQ-031 In PLAY, player1_point rises at edge k -> score1=1 at k, game_on=0 at k, SERVE at k+1, PLAY after 4 more cycles.
REQ-032 Three player2 points -> at third point's k+1, game_over=1, winner=10, score2=3; a start pulse then gives scores 0, winner 00, SERVE.
REQ-033 Both point inputs rise in the same PLAY cycle -> scores unchanged, POINT then SERVE.
REQ-034 player1_point held high across SERVE and into PLAY -> no score change until it falls and rises again in PLAY.
REQ-035 SCORE_KEEPER_WIN_BY_TWO_EN defined, WIN_SCORE=3: score 3-2 -> no win; the next player1 point makes it 4-2 -> winner=01; reset asserted in SERVE -> IDLE, all outputs per REQ-026 next cycle.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: two-player score FSM (IDLE/SERVE/PLAY/POINT/OVER) driving a ball tracker.
// Ports: clk; reset (sync, active-low); start, player1_point, player2_point (level, rising-edge events);
//        game_on / ball_rst_n (high only in PLAY); score1, score2 (saturating 4-bit);
//        game_over (high only in OVER); winner (00 none, 01 player 1, 10 player 2).
// Option: define SCORE_KEEPER_WIN_BY_TWO_EN to require a two-point lead (or a score of 15) to win.
module score_keeper #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SERVE_DELAY = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       player1_point,
  input  logic       player2_point,
  output logic       game_on,
  output logic       ball_rst_n,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic [1:0] winner
);
  localparam int CW = $clog2(SERVE_DELAY + 1);
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] s1_n, s2_n;
  logic [1:0] win_n;
  logic start_q, p1_q, p2_q, start_blk;
  logic start_ev, p1_ev, p2_ev, win1, win2;
  // start_blk remembers a start that was already high at reset release, so it must drop before counting
  assign start_ev = start & ~start_q & ~start_blk;
  assign p1_ev = player1_point & ~p1_q;
  assign p2_ev = player2_point & ~p2_q;
`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
  assign win1 = score1 >= 4'(WIN_SCORE) && ({1'b0, score1} >= {1'b0, score2} + 5'd2 || score1 == 4'd15);
  assign win2 = score2 >= 4'(WIN_SCORE) && ({1'b0, score2} >= {1'b0, score1} + 5'd2 || score2 == 4'd15);
`else
  assign win1 = score1 >= 4'(WIN_SCORE);
  assign win2 = score2 >= 4'(WIN_SCORE);
`endif
  assign game_on = state == PLAY;
  assign ball_rst_n = state == PLAY;
  assign game_over = state == OVER;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      score1    <= '0;
      score2    <= '0;
      winner    <= '0;
      start_q   <= 1'b0;
      p1_q      <= 1'b0;
      p2_q      <= 1'b0;
      start_blk <= start;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      score1    <= s1_n;
      score2    <= s2_n;
      winner    <= win_n;
      start_q   <= start;
      p1_q      <= player1_point;
      p2_q      <= player2_point;
      start_blk <= start_blk & start;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    s1_n    = score1;
    s2_n    = score2;
    win_n   = winner;
    case (state)
      IDLE: if (start_ev) begin
        state_n = SERVE;
        cnt_n   = '0;
      end
      SERVE: if (cnt == CW'(SERVE_DELAY - 1)) state_n = PLAY;
             else cnt_n = cnt + CW'(1);
      PLAY: if (p1_ev | p2_ev) begin
        state_n = POINT;
        s1_n = (p1_ev & ~p2_ev) ? ((score1 == 4'd15) ? score1 : score1 + 4'd1) : score1;
        s2_n = (p2_ev & ~p1_ev) ? ((score2 == 4'd15) ? score2 : score2 + 4'd1) : score2;
      end
      POINT: if (win1 | win2) begin
        state_n = OVER;
        win_n   = win1 ? 2'b01 : 2'b10;
      end else begin
        state_n = SERVE;
        cnt_n   = '0;
      end
      OVER: if (start_ev) begin
        state_n = SERVE;
        cnt_n   = '0;
        s1_n    = '0;
        s2_n    = '0;
        win_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed stimulus with a cycle model and literal checkpoints for score_keeper.
module tb_score_keeper;
  localparam int WS = 3;
  localparam int SD = 4;
`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
  localparam bit BY_TWO = 1'b1;
`else
  localparam bit BY_TWO = 1'b0;
`endif
  logic clk = 1'b0, reset, start, player1_point, player2_point;
  logic game_on, ball_rst_n, game_over;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  int total = 0, bad = 0;
  bit chk_en = 1'b0;
  score_keeper #(.WIN_SCORE(WS), .SERVE_DELAY(SD)) dut (
    .clk(clk), .reset(reset), .start(start), .player1_point(player1_point),
    .player2_point(player2_point), .game_on(game_on), .ball_rst_n(ball_rst_n),
    .score1(score1), .score2(score2), .game_over(game_over), .winner(winner)
  );
  always #5 clk = ~clk;
  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction
  typedef enum {M_IDLE, M_SERVE, M_PLAY, M_POINT, M_OVER} mode_t;
  mode_t mode;
  int m_s1, m_s2, m_win, left;
  bit armed, ps, p1p, p2p;
  function automatic bit won(int a, int b);
    return a >= WS && (!BY_TWO || a - b >= 2 || a == 15);
  endfunction
  function automatic int bump(int a);
    return (a + 1 > 15) ? 15 : a + 1;
  endfunction
  always @(posedge clk) begin
    bit se, e1, e2;
    if (!reset) begin
      mode = M_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; left = 0;
      ps = 0; p1p = 0; p2p = 0; armed = !start;
      chk_en <= 1'b1;
    end else begin
      se = start && !ps && armed;
      e1 = player1_point && !p1p;
      e2 = player2_point && !p2p;
      armed = armed || !start;
      ps = start; p1p = player1_point; p2p = player2_point;
      case (mode)
        M_IDLE: if (se) begin mode = M_SERVE; left = SD; end
        M_SERVE: begin left--; if (left == 0) mode = M_PLAY; end
        M_PLAY: if (e1 || e2) begin
          mode = M_POINT;
          if (e1 && !e2) m_s1 = bump(m_s1);
          if (e2 && !e1) m_s2 = bump(m_s2);
        end
        M_POINT: if (won(m_s1, m_s2) || won(m_s2, m_s1)) begin
          mode = M_OVER;
          m_win = won(m_s1, m_s2) ? 1 : 2;
        end else begin
          mode = M_SERVE; left = SD;
        end
        M_OVER: if (se) begin
          mode = M_SERVE; left = SD; m_s1 = 0; m_s2 = 0; m_win = 0;
        end
        default: mode = M_IDLE;
      endcase
    end
  end
  always @(negedge clk) if (chk_en) begin
    check("m_game_on", game_on, mode == M_PLAY);
    check("m_ball_rst_n", ball_rst_n, mode == M_PLAY);
    check("m_game_over", game_over, mode == M_OVER);
    check("m_score1", score1, m_s1);
    check("m_score2", score2, m_s2);
    check("m_winner", winner, m_win);
  end
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pt(bit a, bit b);
    player1_point = a; player2_point = b;
    step(1);
    player1_point = 0; player2_point = 0;
  endtask
  task automatic wait_play();
    int n = 0;
    while (!game_on && n < 50) begin step(1); n++; end
    check("wait_play", game_on, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 0; start = 1; player1_point = 0; player2_point = 0;
    step(3);
    check("rst_score1", score1, 0);
    check("rst_winner", winner, 0);
    check("rst_ball_rst_n", ball_rst_n, 0);
    reset = 1;
    step(6);
    check("held_start_ignored", game_on, 0);
    start = 0; step(1);
    start = 1; step(1);
    start = 0; step(3);
    check("serve_still", game_on, 0);
    step(1);
    check("serve_to_play", game_on, 1);
    check("serve_ball_rst_n", ball_rst_n, 1);
    pt(1, 0);
    check("p1_score_at_k", score1, 1);
    check("p1_game_on_k", game_on, 0);
    step(4);
    check("p1_serve_k4", game_on, 0);
    step(1);
    check("p1_play_k5", game_on, 1);
    pt(0, 1); wait_play();
    pt(0, 1); wait_play();
    pt(0, 1);
    check("p2_third", score2, 3);
    step(1);
    check("over_flag", game_over, 1);
    check("over_winner", winner, 2'b10);
    check("over_score2", score2, 3);
    pt(1, 0); step(1);
    check("over_ignores_point", score1, 1);
    start = 1; step(1); start = 0;
    check("restart_s1", score1, 0);
    check("restart_s2", score2, 0);
    check("restart_winner", winner, 0);
    pt(0, 1);
    check("serve_ignores_point", score2, 0);
    wait_play();
    pt(1, 1);
    check("both_s1", score1, 0);
    check("both_s2", score2, 0);
    step(1);
    check("both_no_over", game_over, 0);
    wait_play();
    pt(0, 1);
    player1_point = 1;
    wait_play();
    step(2);
    check("held_p1_no_score", score1, 0);
    player1_point = 0; step(1);
    player1_point = 1; step(1);
    check("held_p1_rescored", score1, 1);
    player1_point = 0;
    wait_play();
    pt(1, 0); step(2);
    reset = 0; step(1);
    check("midserve_rst_s1", score1, 0);
    check("midserve_rst_s2", score2, 0);
    check("midserve_rst_on", game_on, 0);
    reset = 1;
    start = 1; step(1); start = 0;
    wait_play();
    pt(1, 0); wait_play();
    pt(1, 0); wait_play();
    pt(0, 1); wait_play();
    pt(0, 1); wait_play();
    pt(1, 0); step(1);
    check("s32_score1", score1, 3);
    if (BY_TWO) begin
      check("s32_no_win", game_over, 0);
      wait_play();
      pt(1, 0); step(1);
      check("s42_score1", score1, 4);
    end
    check("final_over", game_over, 1);
    check("final_winner", winner, 2'b01);
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
